// File: rtl/memory_arbiter.sv
// Arbitrates one single-port RAM between an instruction port and a data port.
// Data normally wins; STARVE_LIMIT bounds how long a waiting instruction fetch can be held off.
`timescale 1ns/1ps
module memory_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic [7:0]  err_count
);

  localparam int CW = $clog2(STARVE_LIMIT + 2);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_starve_cnt;
  logic [7:0]    r_err_count;

  logic w_dreq;
  logic w_access;
  logic w_error;
  logic w_starving;

  assign w_dreq     = dREN | dWEN;
  assign w_access   = (ramstate == RAM_ACCESS);
  assign w_error    = (ramstate == RAM_ERROR);
  assign w_starving = iREN && (r_starve_cnt >= CW'(STARVE_LIMIT));

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_err_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_dreq && !w_starving) begin
            r_state <= DGRANT;
            if (!iREN)
              r_starve_cnt <= '0;
            else if (r_starve_cnt < CW'(STARVE_LIMIT))
              r_starve_cnt <= r_starve_cnt + CW'(1);
          end else if (iREN) begin
            r_state      <= IGRANT;
            r_starve_cnt <= '0;
          end else begin
            r_starve_cnt <= '0;
          end
        end
        IGRANT: begin
          // A dropped request abandons the grant without counting any RAM status.
          if (!iREN || w_access) begin
            r_state <= IDLE;
          end else if (w_error) begin
            r_state <= IDLE;
            if (r_err_count != 8'hFF)
              r_err_count <= r_err_count + 8'd1;
          end
        end
        DGRANT: begin
          if (!w_dreq || w_access) begin
            r_state <= IDLE;
          end else if (w_error) begin
            r_state <= IDLE;
            if (r_err_count != 8'hFF)
              r_err_count <= r_err_count + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // RAM command decodes from the registered grant so a dropped request releases it at once.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (r_state)
      IGRANT: begin
        if (iREN) begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
        end
      end
      DGRANT: begin
        if (w_dreq) begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
        end
      end
      default: ;
    endcase
  end

  assign iwait     = iREN & ~((r_state == IGRANT) && w_access);
  assign dwait     = w_dreq & ~((r_state == DGRANT) && w_access);
  assign iload     = ramload;
  assign dload     = ramload;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized and directed bench for memory_arbiter against a cycle-level reference
// model of the grant/starvation/error rules.
`timescale 1ns/1ps
module tb_memory_arbiter;

  localparam int LIMIT = 4;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0]  ramstate = FREE;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [7:0]  err_count;

  memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err_count(err_count)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the RAM (0 none, 1 instruction, 2 data), starvation run, errors.
  int m_owner = 0;
  int m_starve = 0;
  int m_err = 0;

  logic        obs_ren, obs_wen, obs_iwait, obs_dwait;
  logic [31:0] obs_addr, obs_store;
  logic [7:0]  obs_err;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance model after posedge.
  task automatic step(input logic i, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] ds, input logic [1:0] rs,
                      input string tag);
    logic        dreq, ex_ren, ex_wen, ex_iw, ex_dw, still;
    logic [31:0] ex_addr, ex_store;
    int          n_owner, n_starve, n_err;
    iREN = i; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
    ramstate = rs; ramload = $urandom;
    #4;
    dreq = dr | dw;
    ex_ren = 1'b0; ex_wen = 1'b0; ex_addr = '0; ex_store = '0;
    if (m_owner == 1 && i) begin
      ex_ren = 1'b1; ex_addr = ia;
    end else if (m_owner == 2 && dreq) begin
      ex_addr = da; ex_store = ds; ex_wen = dw; ex_ren = dr & ~dw;
    end
    ex_iw = i & !(m_owner == 1 && rs == ACCESS);
    ex_dw = dreq & !(m_owner == 2 && rs == ACCESS);
    check_value({tag, "_ramREN"}, ramREN, ex_ren);
    check_value({tag, "_ramWEN"}, ramWEN, ex_wen);
    check_value({tag, "_ramaddr"}, ramaddr, ex_addr);
    check_value({tag, "_ramstore"}, ramstore, ex_store);
    check_value({tag, "_iwait"}, iwait, ex_iw);
    check_value({tag, "_dwait"}, dwait, ex_dw);
    check_value({tag, "_iload"}, iload, ramload);
    check_value({tag, "_dload"}, dload, ramload);
    check_value({tag, "_err"}, err_count, m_err);
    obs_ren = ramREN; obs_wen = ramWEN; obs_addr = ramaddr; obs_store = ramstore;
    obs_iwait = iwait; obs_dwait = dwait; obs_err = err_count;

    n_owner = m_owner; n_starve = m_starve; n_err = m_err;
    if (m_owner == 0) begin
      if (dreq && !(i && m_starve >= LIMIT)) begin
        n_owner  = 2;
        n_starve = i ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
      end else if (i) begin
        n_owner  = 1;
        n_starve = 0;
      end else begin
        n_starve = 0;
      end
    end else begin
      still = (m_owner == 1) ? i : dreq;
      if (!still || rs == ACCESS) begin
        n_owner = 0;
      end else if (rs == ERROR) begin
        n_owner = 0;
        n_err   = (m_err >= 255) ? 255 : m_err + 1;
      end
    end
    @(posedge CLK);
    #1;
    m_owner = n_owner; m_starve = n_starve; m_err = n_err;
  endtask

  task automatic do_reset();
    iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0; ramstate = ACCESS;
    nRST = 1'b1;
    #1;
    check_value("rst_ramREN", ramREN, 1'b0);
    check_value("rst_ramWEN", ramWEN, 1'b0);
    check_value("rst_ramaddr", ramaddr, 32'h0);
    check_value("rst_err", err_count, 8'd0);
    check_value("rst_iwait", iwait, 1'b1);
    check_value("rst_dwait", dwait, 1'b1);
    @(posedge CLK);
    #1;
    nRST = 1'b0;
    m_owner = 0; m_starve = 0; m_err = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int k;
    int r;
    logic [1:0] rs;
    @(posedge CLK);
    #1;

    // Single instruction fetch, RAM answers on the first grant cycle
    do_reset();
    step(1, 32'h40, 0, 0, 0, 0, FREE, "t27_req");
    step(1, 32'h40, 0, 0, 0, 0, ACCESS, "t27_grant");
    check_value("t27_ren", obs_ren, 1'b1);
    check_value("t27_addr", obs_addr, 32'h40);
    check_value("t27_iwait", obs_iwait, 1'b0);
    step(1, 32'h40, 0, 0, 0, 0, ACCESS, "t27_idle");
    check_value("t27_idle_ren", obs_ren, 1'b0);
    $display("[TB] directed fetch latency done");

    // Simultaneous requests: data write first, then the instruction
    do_reset();
    step(1, 32'h44, 0, 1, 32'h80, 32'hDEADBEEF, FREE, "t28_req");
    step(1, 32'h44, 0, 1, 32'h80, 32'hDEADBEEF, ACCESS, "t28_dgrant");
    check_value("t28_wen", obs_wen, 1'b1);
    check_value("t28_store", obs_store, 32'hDEADBEEF);
    check_value("t28_daddr", obs_addr, 32'h80);
    check_value("t28_iwait", obs_iwait, 1'b1);
    step(1, 32'h44, 0, 0, 32'h80, 32'hDEADBEEF, FREE, "t28_idle");
    check_value("t28_idle_ren", obs_ren, 1'b0);
    step(1, 32'h44, 0, 0, 32'h80, 32'hDEADBEEF, ACCESS, "t28_igrant");
    check_value("t28_ren", obs_ren, 1'b1);
    check_value("t28_iaddr", obs_addr, 32'h44);
    $display("[TB] directed data-before-instruction done");

    // Starvation bound: four data grants then one instruction grant, repeating
    do_reset();
    k = 0;
    for (int c = 0; c < 20; c++) begin
      step(1, 32'h100, 1, 0, 32'h200, 0, ACCESS, "t29");
      if (obs_ren) begin
        check_value("t29_grant_owner", obs_addr, (k % 5 == 4) ? 32'h100 : 32'h200);
        k++;
      end
    end
    check_value("t29_grant_count", k, 10);
    $display("[TB] directed starvation pattern done");

    // Write wins over read, command held through BUSY
    do_reset();
    step(0, 0, 1, 1, 32'h300, 32'h55, FREE, "t30_req");
    for (int j = 0; j < 4; j++) begin
      step(0, 0, 1, 1, 32'h300, 32'h55, (j == 3) ? ACCESS : BUSY, "t30_hold");
      check_value("t30_wen", obs_wen, 1'b1);
      check_value("t30_ren", obs_ren, 1'b0);
      check_value("t30_addr", obs_addr, 32'h300);
      check_value("t30_dwait", obs_dwait, (j == 3) ? 1'b0 : 1'b1);
    end
    step(0, 0, 1, 1, 32'h300, 32'h55, FREE, "t30_idle");
    check_value("t30_idle_wen", obs_wen, 1'b0);
    $display("[TB] directed busy hold done");

    // RAM error: retry after IDLE, error counter saturates
    do_reset();
    step(1, 32'h40, 0, 0, 0, 0, FREE, "t31_req");
    step(1, 32'h40, 0, 0, 0, 0, ERROR, "t31_err");
    check_value("t31_iwait", obs_iwait, 1'b1);
    step(1, 32'h40, 0, 0, 0, 0, FREE, "t31_idle");
    check_value("t31_err1", obs_err, 8'd1);
    check_value("t31_idle_ren", obs_ren, 1'b0);
    step(1, 32'h40, 0, 0, 0, 0, ERROR, "t31_regrant");
    check_value("t31_regrant_ren", obs_ren, 1'b1);
    for (int j = 0; j < 600; j++)
      step(1, 32'h40, 0, 0, 0, 0, ERROR, "t31_sat");
    check_value("t31_err_sat", err_count, 8'd255);
    step(0, 0, 0, 0, 0, 0, FREE, "t31_drop");
    $display("[TB] directed error retry and saturation done");

    // Asynchronous reset in the middle of a BUSY data grant
    step(0, 0, 0, 1, 32'h400, 32'h77, FREE, "t32_req");
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b1; daddr = 32'h400; dstore = 32'h77; ramstate = BUSY;
    #2;
    check_value("t32_pre_wen", ramWEN, 1'b1);
    nRST = 1'b1;
    #1;
    check_value("t32_wen", ramWEN, 1'b0);
    check_value("t32_ren", ramREN, 1'b0);
    check_value("t32_err", err_count, 8'd0);
    check_value("t32_dwait", dwait, 1'b1);
    @(posedge CLK);
    #1;
    nRST = 1'b0;
    m_owner = 0; m_starve = 0; m_err = 0;
    step(1, 32'h48, 0, 0, 0, 0, FREE, "t32_ireq");
    step(1, 32'h48, 0, 0, 0, 0, BUSY, "t32_igrant");
    check_value("t32_igrant_ren", obs_ren, 1'b1);
    check_value("t32_igrant_addr", obs_addr, 32'h48);
    $display("[TB] directed mid-grant reset done");

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(9);
      rs = (r < 3) ? FREE : (r < 5) ? BUSY : (r < 9) ? ACCESS : ERROR;
      step(($urandom % 4) != 0, $urandom, ($urandom % 3) == 0, ($urandom % 4) == 0,
           $urandom, $urandom, rs, "rnd");
      if (c % 700 == 699) do_reset();
    end
    $display("[TB] randomized traffic done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive data grants while an instruction request waits.
REQ-002 Port: CLK  in  1  system clock, all state on rising edge.
REQ-003 Port: nRST  in  1  asynchronous reset, active-high (asserted when nRST=1).
REQ-004 Port: iREN  in  1  instruction read request; iaddr  in  32  instruction address.
REQ-005 Port: iwait  out  1  instruction stall; iload  out  32  instruction read data.
REQ-006 Port: dREN, dWEN  in  1 each  data read/write request; daddr, dstore  in  32 each.
REQ-007 Port: dwait  out  1  data stall; dload  out  32  data read data.
REQ-008 Port: ramREN, ramWEN  out  1 each; ramaddr, ramstore  out  32 each  single-port RAM command.
REQ-009 Port: ramload  in  32  RAM read data; ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-010 Port: err_count  out  8  saturating count of RAM ERROR completions.

Function
REQ-011 The FSM SHALL have states IDLE, IGRANT and DGRANT, all registered.
REQ-012 IDLE: arbitration decision registered, no RAM command driven (ramREN=ramWEN=0, ramaddr=ramstore=0).
REQ-013 IDLE -> DGRANT if (dREN|dWEN) and not starving; -> IGRANT if iREN and (no data request or starving); else stay.
REQ-014 Starving = iREN & starve_cnt >= STARVE_LIMIT; starve_cnt increments on each DGRANT entry while iREN=1, clears on IGRANT entry or when iREN=0 in IDLE, saturates at STARVE_LIMIT.
REQ-015 IGRANT: ramREN=1, ramWEN=0, ramaddr=iaddr; DGRANT: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN & ~dWEN (write wins when both set).
REQ-016 Completion = ramstate==ACCESS in a GRANT state; in that cycle owner's wait SHALL be 0 and next state IDLE.
REQ-017 iwait = iREN & ~(IGRANT & ramstate==ACCESS); dwait = (dREN|dWEN) & ~(DGRANT & ramstate==ACCESS); both combinational.
REQ-018 iload = ramload and dload = ramload combinationally, at all times.
REQ-019 ramstate FREE or BUSY in a GRANT state SHALL hold state and hold RAM command stable.
REQ-020 ramstate ERROR in a GRANT state: wait stays 1, next state IDLE (request re-arbitrated, retried), err_count +1 saturating at 255.
REQ-021 Owner dropping its request while granted (iREN=0 in IGRANT, dREN=dWEN=0 in DGRANT): RAM command deasserted same cycle, next state IDLE, no completion.
REQ-022 Minimum latency: request in cycle N with arbiter in IDLE, RAM command in cycle N+1, earliest wait=0 in N+1 if RAM returns ACCESS.
REQ-023 No request SHALL be granted twice for one completion; after completion at least one IDLE cycle precedes next grant.

Reset
REQ-024 nRST=1 SHALL immediately force state=IDLE, starve_cnt=0, err_count=0, RAM command outputs 0, regardless of an in-flight grant.
REQ-025 During reset iwait/dwait follow REQ-017 (equal to raw requests); iload/dload follow ramload.
REQ-026 After nRST falls, first arbitration occurs on the next rising CLK edge.

Verification
REQ-027 iREN=1, iaddr=0x40, ramstate ACCESS on 1st grant cycle -> ramREN=1, ramaddr=0x40 in cycle 1, iwait=0 and iload=ramload in cycle 1, IDLE in cycle 2.
REQ-028 iREN=1 and dWEN=1 (daddr=0x80, dstore=0xDEADBEEF) together -> DGRANT first, ramWEN=1, ramstore=0xDEADBEEF; IGRANT after data completion.
REQ-029 dREN held continuously with iREN=1, STARVE_LIMIT=4 -> exactly 4 data grants then 1 instruction grant, pattern repeats.
REQ-030 dREN=dWEN=1, ramstate BUSY 3 cycles then ACCESS -> ramWEN=1, ramREN=0, command stable 4 cycles, dwait=0 only on 4th.
REQ-031 ramstate ERROR on an IGRANT -> iwait stays 1, err_count=1, re-grant after IDLE; 300 errors -> err_count=255.
REQ-032 nRST pulse mid-DGRANT with BUSY RAM -> ramWEN/ramREN=0 immediately, state IDLE, counters 0; iREN-only request after release granted next edge.
